axis_packet_arbiter: RTL and testbench
======================================

// Module: axis_packet_arbiter
//
// PURPOSE
// Many-to-one counterpart of the broadcaster: merges NUM_STREAMS AXI stream
// inputs onto one output at packet granularity.
// Round-robin arbitration; a granted input holds the output until its tlast
// beat is accepted, so packets are never interleaved.
// Output is registered and tagged with the source index. Sits in front of
// shared consumers (e.g. a single MAC/UART TX fed by several producers).
//
// PARAMETERS
// AXIS_BYTES   1  data width in bytes (tdata = AXIS_BYTES*8 bits)
// NUM_STREAMS  2  number of input streams, >= 1
// ID_BITS      derived localparam, = max(1, $clog2(NUM_STREAMS))
//
// PORTS
// clk            in   1                     clock, all logic rising-edge
// sreset         in   1                     synchronous reset, active-high
// axis_i_tready  out  NUM_STREAMS           per-input ready
// axis_i_tvalid  in   NUM_STREAMS           per-input valid
// axis_i_tlast   in   NUM_STREAMS           per-input last
// axis_i_tdata   in   NUM_STREAMS*AXIS_BYTES*8  packed inputs, stream i at [(i+1)*W-1 -: W]
// axis_o_tready  in   1                     output ready
// axis_o_tvalid  out  1                     output valid (registered)
// axis_o_tlast   out  1                     output last (registered)
// axis_o_tdata   out  AXIS_BYTES*8          output data (registered)
// axis_o_tid     out  ID_BITS               index of source stream for this beat
//
// BEHAVIOUR
// - Reset (sreset high at a clk edge):
//   - state=IDLE, grant=0, last_grant=NUM_STREAMS-1 (stream 0 wins first).
//   - axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, axis_o_tid=0.
//   - Reset mid-packet discards the held output beat and the rest of the packet.
// - axis_i_tready is 0 in IDLE and during reset.
// - States:
//   - IDLE: if any axis_i_tvalid, grant <= first k with tvalid[k] set, searching
//     last_grant+1, +2, ... modulo NUM_STREAMS; go to LOCKED. Otherwise stay.
//   - LOCKED: axis_i_tready[grant] = !axis_o_tvalid || axis_o_tready; all other
//     readies are 0.
//     - On an input handshake: tdata/tlast are loaded into the output register,
//       axis_o_tid <= grant, axis_o_tvalid <= 1.
//     - If the accepted beat has tlast=1: last_grant <= grant, next state IDLE.
//     - If the granted input drops tvalid mid-packet: stay LOCKED, wait; never
//       switch streams mid-packet.
// - Output register: on an output handshake with no new input beat,
//   axis_o_tvalid <= 0. Simultaneous in and out handshakes replace the beat
//   (full throughput inside a packet).
// - Output signals are stable while axis_o_tvalid && !axis_o_tready (AXI rule).
// - Latency: input beat appears on the output 1 cycle after its handshake.
// - One idle arbitration cycle per packet: the first beat of a packet is
//   accepted no earlier than 1 cycle after its tvalid is seen in IDLE.
// - Single-beat packets (tvalid and tlast on the first beat) are legal: one
//   beat, then back to IDLE.
// - Fairness: with all inputs continuously valid, grants cycle 0,1,..,N-1,0,...
// - NUM_STREAMS=1: always grants 0, tid constantly 0; the block acts as a
//   register stage with one bubble per packet.
// - Input-side ready depends combinationally on axis_o_tready; no other
//   combinational in-to-out paths.
//
// TESTING
// - Reset: sreset high for 2 cycles with all inputs valid -> all readies 0,
//   o_tvalid 0. First grant after release is stream 0.
// - Single stream: 4-beat packet on input 1 (data 0x10..0x13, last on 0x13),
//   o_tready=1 -> output 0x10..0x13 on consecutive cycles, tid=1, tlast only
//   on 0x13.
// - Contention: N=3, all inputs send 2-beat packets continuously -> output
//   packet order 0,1,2,0,1,2, no beats interleaved, one bubble between packets.
// - Backpressure: random o_tready (50%) during a packet -> no lost or
//   duplicated beats, output held stable while stalled, scoreboard matches
//   per-source order.
// - Mid-packet gap: input 0 drops tvalid for 3 cycles mid-packet while input 1
//   is valid -> input 1 not granted until input 0's tlast is accepted.
// - Reset mid-packet: assert sreset on the 2nd of 4 beats -> o_tvalid=0 next
//   cycle. After release, a new packet from stream 0 passes intact.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: merges NUM_STREAMS AXI-stream inputs onto one registered
// output. The arbiter is round-robin at packet granularity, so a granted input
// owns the output until its tlast beat is accepted. Each output beat carries
// the index of its source stream in axis_o_tid.
module axis_packet_arbiter #(
  parameter int AXIS_BYTES  = 1,
  parameter int NUM_STREAMS = 2,
  localparam int ID_BITS    = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                                clk,
  input  logic                                sreset,
  output logic [NUM_STREAMS-1:0]              axis_i_tready,
  input  logic [NUM_STREAMS-1:0]              axis_i_tvalid,
  input  logic [NUM_STREAMS-1:0]              axis_i_tlast,
  input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                                axis_o_tready,
  output logic                                axis_o_tvalid,
  output logic                                axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]             axis_o_tdata,
  output logic [ID_BITS-1:0]                  axis_o_tid
);

  localparam int W = AXIS_BYTES * 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [ID_BITS-1:0] grant_q, grant_d;
  logic [ID_BITS-1:0] last_grant_q, last_grant_d;

  logic               arb_found;
  logic [ID_BITS-1:0] arb_idx;

  logic               sel_vld;
  logic               sel_last;
  logic [W-1:0]       sel_data;

  logic               in_rdy;
  logic               in_hs;
  logic               out_hs;

  logic               o_vld_q;
  logic               o_last_q;
  logic [W-1:0]       o_data_q;
  logic [ID_BITS-1:0] o_tid_q;

  // Round-robin search: first valid input after last_grant, wrapping around.
  always_comb begin
    int k;
    arb_found = 1'b0;
    arb_idx   = '0;
    k         = 0;
    for (int o = 1; o <= NUM_STREAMS; o++) begin
      k = (int'(last_grant_q) + o) % NUM_STREAMS;
      for (int j = 0; j < NUM_STREAMS; j++) begin
        if (!arb_found && (j == k) && axis_i_tvalid[j]) begin
          arb_found = 1'b1;
          arb_idx   = ID_BITS'(j);
        end
      end
    end
  end

  // Route the granted input's valid/last/data to the shared datapath.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int j = 0; j < NUM_STREAMS; j++) begin
      if (grant_q == ID_BITS'(j)) begin
        sel_vld  = axis_i_tvalid[j];
        sel_last = axis_i_tlast[j];
        sel_data = axis_i_tdata[j*W +: W];
      end
    end
  end

  // The output register can take a new beat when empty or being drained this
  // cycle; this is the only combinational path from axis_o_tready inward.
  assign in_rdy = !o_vld_q || axis_o_tready;
  assign in_hs  = (state_q == LOCKED) && !sreset && sel_vld && in_rdy;
  assign out_hs = o_vld_q && axis_o_tready;

  // FSM state register: arbitration state, current grant and round-robin pointer.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_BITS'(NUM_STREAMS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // FSM next state: lock onto a winner in IDLE, release after the tlast beat.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (in_hs && sel_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only the granted input sees ready, and only while locked.
  always_comb begin
    axis_i_tready = '0;
    if (state_q == LOCKED && !sreset) begin
      for (int j = 0; j < NUM_STREAMS; j++) begin
        if (grant_q == ID_BITS'(j)) axis_i_tready[j] = in_rdy;
      end
    end
  end

  // Output register: load on input handshake, empty on a bare output handshake.
  always_ff @(posedge clk) begin
    if (sreset) begin
      o_vld_q  <= 1'b0;
      o_last_q <= 1'b0;
      o_data_q <= '0;
      o_tid_q  <= '0;
    end else if (in_hs) begin
      o_vld_q  <= 1'b1;
      o_last_q <= sel_last;
      o_data_q <= sel_data;
      o_tid_q  <= grant_q;
    end else if (out_hs) begin
      o_vld_q  <= 1'b0;
    end
  end

  assign axis_o_tvalid = o_vld_q;
  assign axis_o_tlast  = o_last_q;
  assign axis_o_tdata  = o_data_q;
  assign axis_o_tid    = o_tid_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Testbench for axis_packet_arbiter with three 8-bit input streams. Stimulus
// tasks drive packets and queue the expected output beats; a monitor pops the
// queue on every output handshake and checks hold-stability under stall.
module tb_axis_packet_arbiter;
  localparam int N = 3;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           sreset;
  logic [N-1:0]   i_tready;
  logic [N-1:0]   i_tvalid;
  logic [N-1:0]   i_tlast;
  logic [N*W-1:0] i_tdata;
  logic           o_tready;
  logic           o_tvalid;
  logic           o_tlast;
  logic [W-1:0]   o_tdata;
  logic [1:0]     o_tid;

  logic           s_vld [N];
  logic           s_lst [N];
  logic [7:0]     s_dat [N];

  typedef struct packed {
    logic [1:0] tid;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  axis_packet_arbiter #(.AXIS_BYTES(1), .NUM_STREAMS(N)) dut (
    .clk          (clk),
    .sreset       (sreset),
    .axis_i_tready(i_tready),
    .axis_i_tvalid(i_tvalid),
    .axis_i_tlast (i_tlast),
    .axis_i_tdata (i_tdata),
    .axis_o_tready(o_tready),
    .axis_o_tvalid(o_tvalid),
    .axis_o_tlast (o_tlast),
    .axis_o_tdata (o_tdata),
    .axis_o_tid   (o_tid)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    for (int k = 0; k < N; k++) begin
      i_tvalid[k]       = s_vld[k];
      i_tlast[k]        = s_lst[k];
      i_tdata[k*W +: W] = s_dat[k];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_pkt(input int s, input int n, input logic [7:0] base);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.tid  = 2'(s);
      e.data = base + 8'(b);
      e.last = (b == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Drive one packet on stream s; optionally drop tvalid for gap_len cycles before beat gap_after.
  task automatic send_pkt(input int s, input int n, input logic [7:0] base,
                          input int gap_after, input int gap_len);
    int t;
    for (int b = 0; b < n; b++) begin
      if (b == gap_after && gap_len > 0) begin
        s_vld[s] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      s_vld[s] = 1'b1;
      s_dat[s] = base + 8'(b);
      s_lst[s] = (b == n - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (i_tready[s]) break;
        t++;
        if (t > 200) begin
          chk("handshake_timeout", 32'(s), 32'hFFFF);
          s_vld[s] = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    s_vld[s] = 1'b0;
    s_lst[s] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare each accepted output beat and enforce stability while stalled.
  logic       stalled = 1'b0;
  beat_t      held;
  always @(negedge clk) begin
    beat_t e;
    if (sreset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_stable", {o_tvalid, o_tid, o_tdata, o_tlast},
            {1'b1, held.tid, held.data, held.last});
      end
      if (o_tvalid && o_tready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {o_tid, o_tdata, o_tlast}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {o_tid, o_tdata, o_tlast}, {e.tid, e.data, e.last});
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
      end else if (o_tvalid) begin
        stalled   = 1'b1;
        held.tid  = o_tid;
        held.data = o_tdata;
        held.last = o_tlast;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    int t;
    sreset   = 1'b1;
    o_tready = 1'b1;
    for (int s = 0; s < N; s++) begin
      s_vld[s] = 1'b1;
      s_lst[s] = 1'b1;
      s_dat[s] = 8'hA0 + 8'(s);
    end

    // Reset with all inputs valid
    repeat (2) begin
      @(negedge clk);
      chk("rst_tready", 32'(i_tready), 32'h0);
      chk("rst_o_tvalid", 32'(o_tvalid), 32'h0);
    end
    @(posedge clk);
    #1;
    chk("rst_outputs", {o_tid, o_tdata, o_tlast}, 32'h0);
    sreset = 1'b0;
    expect_pkt(0, 1, 8'hA0);
    expect_pkt(1, 1, 8'hA1);
    expect_pkt(2, 1, 8'hA2);
    fork
      begin
        @(posedge clk);
        #1;
        chk("first_grant", 32'(i_tready), 32'h1);
      end
      send_pkt(0, 1, 8'hA0, -1, 0);
      send_pkt(1, 1, 8'hA1, -1, 0);
      send_pkt(2, 1, 8'hA2, -1, 0);
    join
    drain();

    // Contention: each stream sends two 2-beat packets back to back
    first_cyc = -1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++)
        expect_pkt(s, 2, 8'h20 + 8'(16 * s) + 8'(4 * p));
    fork
      begin send_pkt(0, 2, 8'h20, -1, 0); send_pkt(0, 2, 8'h24, -1, 0); end
      begin send_pkt(1, 2, 8'h30, -1, 0); send_pkt(1, 2, 8'h34, -1, 0); end
      begin send_pkt(2, 2, 8'h40, -1, 0); send_pkt(2, 2, 8'h44, -1, 0); end
    join
    drain();
    chk("contention_span", 32'(last_cyc - first_cyc), 32'd16);

    // Single stream: 4-beat packet on input 1 with no backpressure
    first_cyc = -1;
    expect_pkt(1, 4, 8'h10);
    send_pkt(1, 4, 8'h10, -1, 0);
    drain();
    chk("single_span", 32'(last_cyc - first_cyc), 32'd3);

    // Backpressure: random output ready during a 6-beat packet
    expect_pkt(2, 6, 8'h50);
    fork
      send_pkt(2, 6, 8'h50, -1, 0);
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          o_tready = 1'($urandom_range(0, 1));
        end
        o_tready = 1'b1;
      end
    join
    drain();

    // Mid-packet gap on stream 0 while stream 1 waits
    expect_pkt(0, 4, 8'h60);
    expect_pkt(1, 2, 8'h70);
    fork
      send_pkt(0, 4, 8'h60, 2, 3);
      send_pkt(1, 2, 8'h70, -1, 0);
    join
    drain();

    // Reset mid-packet: first beat held at the output, reset on the second beat
    o_tready = 1'b0;
    s_vld[0] = 1'b1;
    s_dat[0] = 8'h80;
    s_lst[0] = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (i_tready[0] || t > 50) break;
      t++;
    end
    @(posedge clk);
    #1;
    chk("mid_rst_held_vld", 32'(o_tvalid), 32'h1);
    chk("mid_rst_held_data", 32'(o_tdata), 32'h80);
    s_dat[0] = 8'h81;
    sreset   = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_o_tvalid", 32'(o_tvalid), 32'h0);
    chk("mid_rst_tready", 32'(i_tready), 32'h0);
    s_vld[0] = 1'b0;
    sreset   = 1'b0;
    o_tready = 1'b1;
    expect_pkt(0, 3, 8'h90);
    send_pkt(0, 3, 8'h90, -1, 0);
    drain();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
